// File: rtl/if_id_fetch.sv
// IF stage PC plus the IF/ID pipeline register, with a RUN/HALTED fetch FSM.
// Optional perf counters (stallCnt, flushCnt) are built when IFID_PERF_CNT_EN is defined.
module if_id_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branchTaken_m,
   input  logic [15:0] branchTarget_m,
   input  logic        halt_d,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic [15:0] pc_f,
   output logic [15:0] instr_d,
   output logic [15:0] currPC_d,
   output logic [15:0] pcPlus2_d,
   output logic        nop_d,
`ifdef IFID_PERF_CNT_EN
   output logic [15:0] stallCnt,
   output logic [15:0] flushCnt,
`endif
   output logic        halted
);

   localparam logic [0:0]  S_RUN     = 1'b0;
   localparam logic [0:0]  S_HALTED  = 1'b1;
   localparam logic [15:0] NOP_INSTR = 16'h0800;

   logic [0:0]  state;
   logic [15:0] pc_plus2;

   assign pc_plus2 = pc_f + 16'd2;
   assign halted   = (state == S_HALTED);

   // A bubble keeps currPC_d/pcPlus2_d; only instr_d and nop_d change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         pc_f      <= 16'h0000;
         instr_d   <= NOP_INSTR;
         currPC_d  <= 16'h0000;
         pcPlus2_d <= 16'h0000;
         nop_d     <= 1'b1;
      end else if (branchTaken_m) begin
         state   <= S_RUN;
         pc_f    <= branchTarget_m;
         instr_d <= NOP_INSTR;
         nop_d   <= 1'b1;
      end else if (state == S_RUN && !stall) begin
         if (halt_d && !nop_d) begin
            state   <= S_HALTED;
            instr_d <= NOP_INSTR;
            nop_d   <= 1'b1;
         end else if (!imem_rdy) begin
            instr_d <= NOP_INSTR;
            nop_d   <= 1'b1;
         end else begin
            instr_d   <= imem_data;
            currPC_d  <= pc_f;
            pcPlus2_d <= pc_plus2;
            nop_d     <= 1'b0;
            pc_f      <= pc_plus2;
         end
      end
   end

`ifdef IFID_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCnt <= 16'h0000;
         flushCnt <= 16'h0000;
      end else begin
         if (stall && stallCnt != 16'hFFFF)
            stallCnt <= stallCnt + 16'd1;
         if (branchTaken_m && flushCnt != 16'hFFFF)
            flushCnt <= flushCnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_fetch.sv
// Randomized + directed bench for if_id_fetch against a behavioural fetch model.
module tb_if_id_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branchTaken_m = 1'b0;
   logic [15:0] branchTarget_m = 16'h0000;
   logic        halt_d = 1'b0;
   logic        imem_rdy = 1'b0;
   logic [15:0] imem_data;
   logic [15:0] pc_f, instr_d, currPC_d, pcPlus2_d;
   logic        nop_d, halted;
`ifdef IFID_PERF_CNT_EN
   logic [15:0] stallCnt, flushCnt;
`endif

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   if_id_fetch dut (
      .clk(clk), .rst(rst), .stall(stall), .branchTaken_m(branchTaken_m),
      .branchTarget_m(branchTarget_m), .halt_d(halt_d), .imem_rdy(imem_rdy),
      .imem_data(imem_data), .pc_f(pc_f), .instr_d(instr_d), .currPC_d(currPC_d),
      .pcPlus2_d(pcPlus2_d), .nop_d(nop_d),
`ifdef IFID_PERF_CNT_EN
      .stallCnt(stallCnt), .flushCnt(flushCnt),
`endif
      .halted(halted)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   assign imem_data = mem_word(pc_f);

   // Reference model: architectural fetch state.
   logic [15:0] m_pc = 16'h0000, m_instr = 16'h0800, m_cur = 16'h0000, m_p2 = 16'h0000;
   logic        m_nop = 1'b1, m_halted = 1'b0;
   int          m_sc = 0, m_fc = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 16'h0000; m_instr = 16'h0800; m_cur = 16'h0000; m_p2 = 16'h0000;
         m_nop = 1'b1; m_halted = 1'b0; m_sc = 0; m_fc = 0;
      end else begin
         if (stall)         m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
         if (branchTaken_m) m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
         if (branchTaken_m) begin
            m_pc = branchTarget_m; m_instr = 16'h0800; m_nop = 1'b1; m_halted = 1'b0;
         end else if (!m_halted && !stall) begin
            if (halt_d && !m_nop) begin
               m_halted = 1'b1; m_instr = 16'h0800; m_nop = 1'b1;
            end else if (!imem_rdy) begin
               m_instr = 16'h0800; m_nop = 1'b1;
            end else begin
               m_instr = mem_word(m_pc);
               m_cur   = m_pc;
               m_p2    = 16'((32'(m_pc) + 2) % 65536);
               m_pc    = m_p2;
               m_nop   = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_f",      pc_f,      m_pc);
         chk("instr_d",   instr_d,   m_instr);
         chk("currPC_d",  currPC_d,  m_cur);
         chk("pcPlus2_d", pcPlus2_d, m_p2);
         chk("nop_d",     16'(nop_d),  16'(m_nop));
         chk("halted",    16'(halted), 16'(m_halted));
`ifdef IFID_PERF_CNT_EN
         chk("stallCnt",  stallCnt,  16'(m_sc));
         chk("flushCnt",  flushCnt,  16'(m_fc));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_in(input bit r, input bit s, input bit b, input logic [15:0] t,
                         input bit h, input bit rdy);
      rst = r; stall = s; branchTaken_m = b; branchTarget_m = t; halt_d = h; imem_rdy = rdy;
   endtask

   initial begin
      @(negedge clk);
      set_in(1, 0, 0, 16'h0, 0, 0);
      cyc();
      chk_en = 1'b1;
      chk("rst_pc", pc_f, 16'h0000);
      chk("rst_instr", instr_d, 16'h0800);
      chk("rst_nop", 16'(nop_d), 16'h1);
      chk("rst_halted", 16'(halted), 16'h0);

      // Sequential fetch from 0
      set_in(0, 0, 0, 16'h0, 0, 1);
      cyc();
      chk("seq_pc1", pc_f, 16'h0002);
      chk("seq_cur1", currPC_d, 16'h0000);
      chk("seq_nop1", 16'(nop_d), 16'h0);
      cyc();
      chk("seq_pc2", pc_f, 16'h0004);
      chk("seq_cur2", currPC_d, 16'h0002);

      // Stall at 0x0010
      set_in(0, 0, 1, 16'h0010, 0, 1);
      cyc();
      set_in(0, 1, 0, 16'h0, 0, 1);
      cyc();
      cyc();
      chk("stall_pc", pc_f, 16'h0010);
      chk("stall_instr", instr_d, 16'h0800);
      chk("stall_cur", currPC_d, 16'h0002);
      set_in(0, 0, 0, 16'h0, 0, 1);
      cyc();
      chk("stall_rel_pc", pc_f, 16'h0012);
      chk("stall_rel_cur", currPC_d, 16'h0010);

      // Redirect wins over stall
      set_in(0, 1, 1, 16'h0040, 0, 1);
      cyc();
      chk("br_stall_pc", pc_f, 16'h0040);
      chk("br_stall_nop", 16'(nop_d), 16'h1);

      // HALT at 0x0020, hold 5 cycles, then redirect out
      set_in(0, 0, 1, 16'h0020, 0, 1);
      cyc();
      set_in(0, 0, 0, 16'h0, 0, 1);
      cyc();
      chk("pre_halt_cur", currPC_d, 16'h0020);
      set_in(0, 0, 0, 16'h0, 1, 1);
      cyc();
      set_in(0, 0, 0, 16'h0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         chk("halt_pc", pc_f, 16'h0022);
         chk("halt_flag", 16'(halted), 16'h1);
         chk("halt_nop", 16'(nop_d), 16'h1);
         cyc();
      end
      set_in(0, 0, 1, 16'h0100, 0, 1);
      cyc();
      chk("unhalt_pc", pc_f, 16'h0100);
      chk("unhalt_flag", 16'(halted), 16'h0);

      // Memory not ready, then wrap at 0xFFFE
      set_in(0, 0, 0, 16'h0, 0, 1);
      cyc();
      set_in(0, 0, 0, 16'h0, 0, 0);
      cyc();
      chk("nrdy_pc", pc_f, 16'h0102);
      chk("nrdy_nop", 16'(nop_d), 16'h1);
      chk("nrdy_instr", instr_d, 16'h0800);
      set_in(0, 0, 1, 16'hFFFE, 0, 1);
      cyc();
      set_in(0, 0, 0, 16'h0, 0, 1);
      cyc();
      chk("wrap_pc", pc_f, 16'h0000);
      chk("wrap_cur", currPC_d, 16'hFFFE);
      chk("wrap_p2", pcPlus2_d, 16'h0000);

      // Reset while HALTED
      set_in(0, 0, 0, 16'h0, 1, 1);
      cyc();
      chk("halt2_flag", 16'(halted), 16'h1);
      set_in(1, 1, 1, 16'h1234, 1, 1);
      cyc();
      chk("rst_h_pc", pc_f, 16'h0000);
      chk("rst_h_halted", 16'(halted), 16'h0);
      chk("rst_h_nop", 16'(nop_d), 16'h1);
`ifdef IFID_PERF_CNT_EN
      chk("rst_h_scnt", stallCnt, 16'h0000);
      chk("rst_h_fcnt", flushCnt, 16'h0000);
`endif

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 11) == 0,
                16'($urandom) & 16'hFFFE,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 4) != 0);
         cyc();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_fetch.md
IF_ID_FETCH -- requirements
Module: if_id_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on clk rising edge.
REQ-003 SHALL have port stall, input, 1, hazard stall from decode; hold PC and IF/ID contents.
REQ-004 SHALL have port branchTaken_m, input, 1, branch/jump resolved taken in memory stage; redirect and flush.
REQ-005 SHALL have port branchTarget_m, input, 16, redirect target PC, valid when branchTaken_m=1.
REQ-006 SHALL have port halt_d, input, 1, HALT decoded from the instruction currently in IF/ID.
REQ-007 SHALL have port imem_rdy, input, 1, instruction memory data valid this cycle.
REQ-008 SHALL have port imem_data, input, 16, instruction read at pc_f (combinational memory).
REQ-009 SHALL have port pc_f, output, 16, fetch address to instruction memory.
REQ-010 SHALL have ports instr_d, currPC_d, pcPlus2_d, outputs, 16 each, IF/ID instruction, its PC, its PC+2.
REQ-011 SHALL have port nop_d, output, 1, IF/ID slot holds a bubble; consumed by id_ex as nop_d.
REQ-012 SHALL have port halted, output, 1, fetch frozen by HALT.

Function
REQ-013 SHALL keep a 2-state FSM: RUN, HALTED; PC and IF/ID register update only on clk rising edge.
REQ-014 SHALL apply per-cycle priority: rst > branchTaken_m > HALTED hold > stall > !imem_rdy > normal fetch.
REQ-015 Normal fetch (RUN, stall=0, imem_rdy=1) SHALL load IF/ID with instr_d=imem_data, currPC_d=pc_f, pcPlus2_d=pc_f+2, nop_d=0, and PC<=pc_f+2.
REQ-016 PC+2 SHALL wrap modulo 2^16 (0xFFFE -> 0x0000), no overflow flag.
REQ-017 stall=1 SHALL hold PC and all IF/ID outputs unchanged, including nop_d.
REQ-018 stall=0 with imem_rdy=0 SHALL hold PC and load a bubble: nop_d=1, instr_d=0x0800 (NOP encoding), currPC_d/pcPlus2_d unchanged.
REQ-019 branchTaken_m=1 SHALL set PC<=branchTarget_m and load a bubble into IF/ID in the same edge, regardless of stall, imem_rdy or FSM state.
REQ-020 branchTaken_m=1 in HALTED SHALL return FSM to RUN (the HALT was wrong-path).
REQ-021 In RUN, halt_d=1 with nop_d=0, stall=0, branchTaken_m=0 SHALL move FSM to HALTED; PC holds; IF/ID loads a bubble.
REQ-022 halt_d SHALL be ignored while stall=1 or nop_d=1.
REQ-023 In HALTED, PC and IF/ID SHALL hold; nop_d=1; halted=1; only branchTaken_m or rst leaves.
REQ-024 Fetch-to-decode latency SHALL be exactly 1 cycle; redirect-to-first-fetch of target SHALL be 1 cycle (pc_f=target on next cycle).

Reset
REQ-025 rst=1 SHALL set PC=0x0000, FSM=RUN, instr_d=0x0800, currPC_d=0x0000, pcPlus2_d=0x0000, nop_d=1, halted=0.
REQ-026 rst SHALL override every other input in the same cycle, including mid-redirect and HALTED.

Configuration
REQ-027 With macro IFID_PERF_CNT_EN defined, the block SHALL add outputs stallCnt and flushCnt (16 each), counting cycles with stall=1 and edges with branchTaken_m=1, saturating at 0xFFFF, reset to 0.
REQ-028 Without IFID_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset then 3 cycles imem_rdy=1 -> pc_f 0x0000,0x0002,0x0004; currPC_d 0x0000 then 0x0002, nop_d=0 after first edge.
REQ-030 stall=1 for 2 cycles at pc_f=0x0010 -> pc_f stays 0x0010, instr_d/currPC_d unchanged, resumes 0x0012 after release.
REQ-031 branchTaken_m=1, branchTarget_m=0x0040 with stall=1 -> next cycle pc_f=0x0040, nop_d=1.
REQ-032 halt_d=1 at currPC_d=0x0020 -> halted=1, nop_d=1, pc_f frozen for 5 cycles; then branchTaken_m=1 target 0x0100 -> RUN, pc_f=0x0100.
REQ-033 imem_rdy=0 for 1 cycle -> bubble with nop_d=1, pc_f held; PC 0xFFFE fetch -> next pc_f=0x0000.
REQ-034 rst asserted while HALTED -> halted=0, pc_f=0x0000, nop_d=1; with IFID_PERF_CNT_EN, counters read 0.
